sdr_req_arbiter: RTL and testbench
==================================

# sdr_req_arbiter

Round-robin arbiter that shares the single request port of the SDR SDRAM controller (`sdr_fastinit`) between NREQ independent requesters (AHB slave front-end, DMA engines). It latches one requester's command, presents it on the controller's R_REQ/W_REQ/RADDR/B_SIZE/AUTO_PCH inputs, and returns RW_ACK to that requester. It routes R_VALID/D_REQ beats to the owner and releases the port only after the last data beat.

## Interface
- NREQ, 4: number of requesters, 2..8
- SDRAM_RASIZE, 31: address width, matches controller
- CLK  in  1  system clock, all logic on rising edge
- RESET_N  in  1  reset; synchronous, active-low
- M_RREQ  in  NREQ  per-requester read request; held until M_ACK
- M_WREQ  in  NREQ  per-requester write request; held until M_ACK
- M_RADDR  in  NREQ*SDRAM_RASIZE  packed addresses, requester i at [i*RASIZE +: RASIZE]
- M_BSIZE  in  NREQ*4  packed burst sizes, beats = value+1
- M_AUTOPCH  in  NREQ  auto-precharge per requester
- M_ACK  out  NREQ  one-hot acknowledge, = RW_ACK & M_GNT (combinational)
- M_GNT  out  NREQ  one-hot current owner, 0 when idle
- M_RVALID  out  NREQ  R_VALID steered to owner
- M_DREQ  out  NREQ  D_REQ steered to owner
- R_REQ, W_REQ  out  1  to controller
- RADDR  out  SDRAM_RASIZE  to controller
- B_SIZE  out  4  to controller
- AUTO_PCH  out  1  to controller
- RW_ACK, R_VALID, D_REQ  in  1  from controller

## Operation
- States: IDLE, REQ, DATA.
- IDLE: if any M_RREQ|M_WREQ bit set, pick winner by round-robin starting at last_gnt+1 (mod NREQ). Register M_GNT, RADDR, B_SIZE, AUTO_PCH, and command: read if M_RREQ[i], else write. Read wins when both bits are set on one requester; the write stays pending. Go to REQ.
- REQ: R_REQ or W_REQ held high. On RW_ACK: M_ACK to owner, load beat counter with B_SIZE, deassert R_REQ/W_REQ (registered), go to DATA.
- DATA: count R_VALID (read) or D_REQ (write) beats. On the beat with counter == 0: go to IDLE, set last_gnt = owner, clear M_GNT.
- Latched command is immune to requester changes after grant. Dropping a request before M_ACK is illegal; the command is still issued.
- M_RVALID/M_DREQ = R_VALID/D_REQ & M_GNT, combinational. Beats arriving with M_GNT == 0 are dropped.
- Reset values: state IDLE, M_GNT 0, R_REQ 0, W_REQ 0, RADDR 0, B_SIZE 0, AUTO_PCH 0, beat counter 0, last_gnt NREQ-1 (port 0 wins first).
- Reset mid-burst: all state is cleared next edge. The controller is reset by the same RESET_N.

## Timing
- Request seen in IDLE at edge n -> M_GNT and R_REQ/W_REQ high from cycle n+1.
- M_ACK is in the same cycle as RW_ACK. R_REQ/W_REQ are low the cycle after RW_ACK.
- Return from DATA to IDLE takes 1 cycle after the last beat. The next grant is registered one cycle later.
- Minimum idle gap between bursts: 1 cycle.
- Fairness: a continuously requesting port waits at most NREQ-1 bursts.
- Beat counter is 4 bits. No wrap: counting stops at 0 when the last beat is consumed.

## Configuration
- SDR_ARB_FIXED_PRIO_EN defined: round-robin is disabled. The lowest-index requesting port always wins, last_gnt is unused, and starvation is possible by design (port 0 reserved for the latency-critical master).
- Undefined: round-robin as described above.

## Test plan
- Single read: port 2 M_RREQ, addr 0x100, BSIZE 3 -> R_REQ next cycle, RADDR 0x100, B_SIZE 3, M_ACK[2] with RW_ACK, 4 beats on M_RVALID[2] only, then IDLE.
- All 4 ports request continuously after reset -> grant order 0,1,2,3,0. With SDR_ARB_FIXED_PRIO_EN -> always 0.
- Port 1 asserts both M_RREQ and M_WREQ -> read burst first, then write burst on a later grant, with M_DREQ beats steered to port 1.
- RW_ACK delayed 10 cycles -> R_REQ held for 10 cycles. No new grant while in REQ, even though other ports request.
- RESET_N low for one cycle during DATA beat 2 of 8 -> next cycle M_GNT=0, R_REQ=W_REQ=0, state IDLE. The next grant goes to port 0.
- Stray R_VALID while idle -> all M_RVALID stay 0.

Source files
------------

// File: rtl/sdr_req_arbiter.sv
// Round-robin arbiter sharing the single sdr_fastinit request port among NREQ requesters.
// Define SDR_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module sdr_req_arbiter #(
  parameter int NREQ         = 4,
  parameter int SDRAM_RASIZE = 31
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic [NREQ-1:0]              M_RREQ,
  input  logic [NREQ-1:0]              M_WREQ,
  input  logic [NREQ*SDRAM_RASIZE-1:0] M_RADDR,
  input  logic [NREQ*4-1:0]            M_BSIZE,
  input  logic [NREQ-1:0]              M_AUTOPCH,
  output logic [NREQ-1:0]              M_ACK,
  output logic [NREQ-1:0]              M_GNT,
  output logic [NREQ-1:0]              M_RVALID,
  output logic [NREQ-1:0]              M_DREQ,
  output logic                         R_REQ,
  output logic                         W_REQ,
  output logic [SDRAM_RASIZE-1:0]      RADDR,
  output logic [3:0]                   B_SIZE,
  output logic                         AUTO_PCH,
  input  logic                         RW_ACK,
  input  logic                         R_VALID,
  input  logic                         D_REQ
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_t;

  state_t                  r_state,   w_state_nxt;
  logic [NREQ-1:0]         r_gnt,     w_gnt_nxt;
  logic                    r_rreq,    w_rreq_nxt;
  logic                    r_wreq,    w_wreq_nxt;
  logic                    r_is_read, w_is_read_nxt;
  logic                    r_autopch, w_autopch_nxt;
  logic [SDRAM_RASIZE-1:0] r_raddr,   w_raddr_nxt;
  logic [3:0]              r_bsize,   w_bsize_nxt;
  logic [3:0]              r_cnt,     w_cnt_nxt;
`ifndef SDR_ARB_FIXED_PRIO_EN
  logic [IW-1:0]           r_owner,    w_owner_nxt;
  logic [IW-1:0]           r_last_gnt, w_last_gnt_nxt;
  logic [IW-1:0]           w_cand;
`endif

  logic [NREQ-1:0]         w_any;
  logic                    w_found;
  logic [IW-1:0]           w_win;
  logic                    w_beat;
  logic [SDRAM_RASIZE-1:0] w_addr_arr  [NREQ];
  logic [3:0]              w_bsize_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_addr_arr[g]  = M_RADDR[g*SDRAM_RASIZE +: SDRAM_RASIZE];
    assign w_bsize_arr[g] = M_BSIZE[g*4 +: 4];
  end

  assign w_any  = M_RREQ | M_WREQ;
  assign w_beat = r_is_read ? R_VALID : D_REQ;

  // Candidates are scanned from lowest to highest priority, so the last hit wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    w_found = 1'b0;
    w_win   = '0;
`ifdef SDR_ARB_FIXED_PRIO_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_any[IW'(k)]) begin
        w_found = 1'b1;
        w_win   = IW'(k);
      end
    end
`else
    w_cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = IW'((int'(r_last_gnt) + k) % NREQ);
      if (w_any[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
`endif
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_rreq_nxt     = r_rreq;
    w_wreq_nxt     = r_wreq;
    w_is_read_nxt  = r_is_read;
    w_autopch_nxt  = r_autopch;
    w_raddr_nxt    = r_raddr;
    w_bsize_nxt    = r_bsize;
    w_cnt_nxt      = r_cnt;
`ifndef SDR_ARB_FIXED_PRIO_EN
    w_owner_nxt    = r_owner;
    w_last_gnt_nxt = r_last_gnt;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt        = S_REQ;
          w_gnt_nxt          = '0;
          w_gnt_nxt[w_win]   = 1'b1;
          // Read wins over write on the same port; the write stays pending.
          w_is_read_nxt      = M_RREQ[w_win];
          w_rreq_nxt         = M_RREQ[w_win];
          w_wreq_nxt         = ~M_RREQ[w_win];
          w_raddr_nxt        = w_addr_arr[w_win];
          w_bsize_nxt        = w_bsize_arr[w_win];
          w_autopch_nxt      = M_AUTOPCH[w_win];
`ifndef SDR_ARB_FIXED_PRIO_EN
          w_owner_nxt        = w_win;
`endif
        end
      end
      S_REQ: begin
        if (RW_ACK) begin
          w_state_nxt = S_DATA;
          w_rreq_nxt  = 1'b0;
          w_wreq_nxt  = 1'b0;
          w_cnt_nxt   = r_bsize;
        end
      end
      S_DATA: begin
        if (w_beat) begin
          if (r_cnt == 4'd0) begin
            w_state_nxt    = S_IDLE;
            w_gnt_nxt      = '0;
`ifndef SDR_ARB_FIXED_PRIO_EN
            w_last_gnt_nxt = r_owner;
`endif
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_rreq     <= 1'b0;
      r_wreq     <= 1'b0;
      r_is_read  <= 1'b0;
      r_autopch  <= 1'b0;
      r_raddr    <= '0;
      r_bsize    <= '0;
      r_cnt      <= '0;
`ifndef SDR_ARB_FIXED_PRIO_EN
      r_owner    <= '0;
      r_last_gnt <= IW'(NREQ - 1);
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_rreq     <= w_rreq_nxt;
      r_wreq     <= w_wreq_nxt;
      r_is_read  <= w_is_read_nxt;
      r_autopch  <= w_autopch_nxt;
      r_raddr    <= w_raddr_nxt;
      r_bsize    <= w_bsize_nxt;
      r_cnt      <= w_cnt_nxt;
`ifndef SDR_ARB_FIXED_PRIO_EN
      r_owner    <= w_owner_nxt;
      r_last_gnt <= w_last_gnt_nxt;
`endif
    end
  end

  assign M_GNT    = r_gnt;
  assign M_ACK    = {NREQ{RW_ACK}}  & r_gnt;
  assign M_RVALID = {NREQ{R_VALID}} & r_gnt;
  assign M_DREQ   = {NREQ{D_REQ}}   & r_gnt;
  assign R_REQ    = r_rreq;
  assign W_REQ    = r_wreq;
  assign RADDR    = r_raddr;
  assign B_SIZE   = r_bsize;
  assign AUTO_PCH = r_autopch;

endmodule

// File: tb/tb_sdr_req_arbiter.sv
// Randomised bench for sdr_req_arbiter: requester models, a controller model and a
// transaction-level arbitration reference feeding a scoreboard checked by a monitor.
module tb_sdr_req_arbiter;

  localparam int NREQ = 4;
  localparam int RA   = 31;

  logic                 CLK       = 1'b0;
  logic                 RESET_N   = 1'b0;
  logic [NREQ-1:0]      M_RREQ    = '0;
  logic [NREQ-1:0]      M_WREQ    = '0;
  logic [NREQ*RA-1:0]   M_RADDR   = '0;
  logic [NREQ*4-1:0]    M_BSIZE   = '0;
  logic [NREQ-1:0]      M_AUTOPCH = '0;
  logic [NREQ-1:0]      M_ACK, M_GNT, M_RVALID, M_DREQ;
  logic                 R_REQ, W_REQ, AUTO_PCH;
  logic [RA-1:0]        RADDR;
  logic [3:0]           B_SIZE;
  logic                 RW_ACK  = 1'b0;
  logic                 R_VALID = 1'b0;
  logic                 D_REQ   = 1'b0;

  sdr_req_arbiter #(.NREQ(NREQ), .SDRAM_RASIZE(RA)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .M_RREQ(M_RREQ), .M_WREQ(M_WREQ), .M_RADDR(M_RADDR), .M_BSIZE(M_BSIZE),
    .M_AUTOPCH(M_AUTOPCH), .M_ACK(M_ACK), .M_GNT(M_GNT), .M_RVALID(M_RVALID),
    .M_DREQ(M_DREQ), .R_REQ(R_REQ), .W_REQ(W_REQ), .RADDR(RADDR), .B_SIZE(B_SIZE),
    .AUTO_PCH(AUTO_PCH), .RW_ACK(RW_ACK), .R_VALID(R_VALID), .D_REQ(D_REQ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int           port;
    bit           rd;
    logic [RA-1:0] addr;
    logic [3:0]   bsize;
    bit           ap;
  } cmd_t;

  cmd_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference: one burst owner at a time, tracked as "waiting for ack" then "beats left".
  bit   m_busy  = 1'b0;
  bit   m_acked = 1'b0;
  int   m_left  = 0;
  int   m_last  = NREQ - 1;
  cmd_t m_cur;

  // Handshake between the stimulus thread and the monitor.
  bit   end_req  = 1'b0;
  bit   mon_done = 1'b0;
  int   tmo_cnt  = 0;

  always @(posedge CLK) begin : model
    int   w;
    cmd_t c;
    w = -1;
    if (!RESET_N) begin
      m_busy  = 1'b0;
      m_acked = 1'b0;
      m_last  = NREQ - 1;
    end else if (!m_busy) begin
`ifdef SDR_ARB_FIXED_PRIO_EN
      for (int k = 0; k < NREQ && w < 0; k++)
        if (M_RREQ[k] || M_WREQ[k]) w = k;
`else
      for (int k = 1; k <= NREQ && w < 0; k++)
        if (M_RREQ[(m_last + k) % NREQ] || M_WREQ[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
`endif
      if (w >= 0) begin
        c.port  = w;
        c.rd    = M_RREQ[w];
        c.addr  = M_RADDR[w*RA +: RA];
        c.bsize = M_BSIZE[w*4 +: 4];
        c.ap    = M_AUTOPCH[w];
        exp_q.push_back(c);
        m_cur   = c;
        m_busy  = 1'b1;
        m_acked = 1'b0;
        m_left  = int'(c.bsize) + 1;
      end
    end else if (!m_acked) begin
      if (RW_ACK) m_acked = 1'b1;
    end else if (m_cur.rd ? R_VALID : D_REQ) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_last = m_cur.port;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin : monitor
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] cg;
    cmd_t            c;
    static bit       prev_req   = 1'b0;
    static bit       prev_rst   = 1'b1;
    static int       rd_idx     = 0;
    #3;
    eg = '0;
    if (m_busy) eg[m_cur.port] = 1'b1;
    if (prev_rst) begin
      check("rst_gnt",  M_GNT, 0);
      check("rst_rreq", R_REQ, 0);
      check("rst_wreq", W_REQ, 0);
    end
    check("gnt",    M_GNT,    eg);
    check("r_req",  R_REQ,    m_busy && !m_acked && m_cur.rd);
    check("w_req",  W_REQ,    m_busy && !m_acked && !m_cur.rd);
    check("ack",    M_ACK,    RW_ACK  ? eg : '0);
    check("rvalid", M_RVALID, R_VALID ? eg : '0);
    check("dreq",   M_DREQ,   D_REQ   ? eg : '0);
    if (m_busy) begin
      check("raddr_hold", RADDR,    m_cur.addr);
      check("bsize_hold", B_SIZE,   m_cur.bsize);
      check("apch_hold",  AUTO_PCH, m_cur.ap);
    end
    if ((R_REQ || W_REQ) && !prev_req) begin
      if (rd_idx < exp_q.size()) begin
        c  = exp_q[rd_idx];
        rd_idx++;
        cg = '0;
        cg[c.port] = 1'b1;
        check("cmd_port",  M_GNT,    cg);
        check("cmd_dir",   R_REQ,    c.rd);
        check("cmd_addr",  RADDR,    c.addr);
        check("cmd_bsize", B_SIZE,   c.bsize);
        check("cmd_apch",  AUTO_PCH, c.ap);
      end else begin
        check("cmd_unexpected", rd_idx, exp_q.size());
      end
    end
    prev_req = R_REQ || W_REQ;
    prev_rst = !RESET_N;
    if (end_req && !mon_done) begin
      check("q_drained",     rd_idx,  exp_q.size());
      check("wait_timeouts", tmo_cnt, 0);
      mon_done = 1'b1;
    end
  end

  // Controller model: acks after a variable delay, then returns B_SIZE+1 beats with gaps.
  always @(negedge CLK) begin : ctrl_bfm
    static int bstate = 0;
    static int bdly   = 0;
    static int bleft  = 0;
    static bit brd    = 1'b0;
    #1;
    if (!RESET_N) begin
      bstate  = 0;
      RW_ACK  = 1'b0;
      R_VALID = 1'b0;
      D_REQ   = 1'b0;
    end else begin
      case (bstate)
        0: begin
          RW_ACK  = 1'b0;
          R_VALID = 1'b0;
          D_REQ   = 1'b0;
          if (R_REQ || W_REQ) begin
            brd    = R_REQ;
            bleft  = int'(B_SIZE) + 1;
            bdly   = ($urandom_range(0, 7) == 0) ? 10 : int'($urandom_range(0, 2));
            bstate = 1;
          end else if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 1) R_VALID = 1'b1;
            else                           D_REQ   = 1'b1;
          end
        end
        1: begin
          if (bdly == 0) begin
            RW_ACK = 1'b1;
            bstate = 2;
          end else begin
            bdly--;
          end
        end
        default: begin
          RW_ACK  = 1'b0;
          R_VALID = 1'b0;
          D_REQ   = 1'b0;
          if ($urandom_range(0, 3) != 0) begin
            if (brd) R_VALID = 1'b1;
            else     D_REQ   = 1'b1;
            bleft--;
            if (bleft == 0) bstate = 0;
          end
        end
      endcase
    end
  end

  logic [NREQ-1:0] acks = '0;

  task automatic new_req(input int p, input bit rd, input bit wr, input logic [RA-1:0] a,
                         input logic [3:0] bs, input bit ap);
    M_RREQ[p]          = rd;
    M_WREQ[p]          = wr;
    M_RADDR[p*RA +: RA] = a;
    M_BSIZE[p*4 +: 4]  = bs;
    M_AUTOPCH[p]       = ap;
  endtask

  // One requester cycle: retire acked commands, optionally raise new ones, sample acks.
  task automatic cycle_step(input bit gen);
    int kind;
    @(negedge CLK);
    for (int i = 0; i < NREQ; i++) begin
      if (acks[i]) begin
        if (M_RREQ[i]) M_RREQ[i] = 1'b0;
        else           M_WREQ[i] = 1'b0;
      end
    end
    if (gen) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!M_RREQ[i] && !M_WREQ[i] && $urandom_range(0, 2) == 0) begin
          kind = int'($urandom_range(0, 3));
          new_req(i, kind != 2, kind >= 2, RA'($urandom), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
        end
      end
    end
    #3;
    acks = M_ACK;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((m_busy || (M_RREQ | M_WREQ) != '0) && c < 2000) begin
      cycle_step(1'b0);
      c++;
    end
    if (c >= 2000) tmo_cnt++;
  endtask

  initial begin
    int c;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < NREQ; i++)
      new_req(i, 1'b1, 1'b0, RA'($urandom), 4'($urandom_range(0, 15)), 1'b0);
    #3;
    acks = M_ACK;

    repeat (3000) cycle_step(1'b1);
    drain();

    // Reset in the middle of an 8-beat read on port 1 while ports 0 and 2 wait.
    @(negedge CLK);
    new_req(1, 1'b1, 1'b0, RA'('h100), 4'd7, 1'b0);
    #3;
    acks = M_ACK;
    c = 0;
    while (!(m_busy && m_cur.port == 1 && m_acked && m_left == 6) && c < 400) begin
      cycle_step(1'b0);
      c++;
    end
    if (c >= 400) tmo_cnt++;
    @(negedge CLK);
    RESET_N = 1'b0;
    new_req(0, 1'b1, 1'b0, RA'('h200), 4'd1, 1'b1);
    new_req(2, 1'b0, 1'b1, RA'('h300), 4'd0, 1'b0);
    #3;
    acks = M_ACK;
    @(negedge CLK);
    RESET_N = 1'b1;
    #3;
    acks = M_ACK;
    drain();

    end_req = 1'b1;
    c = 0;
    while (!mon_done && c < 10) begin
      @(negedge CLK);
      c++;
    end
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
